// File: rtl/alu_vector_driver.sv
// Self-test initiator for the combinational ALU: drives a directed preamble then LFSR vectors,
// checks result/zero against a built-in golden model, and reports pass/fail and the first failure.
module alu_vector_driver #(
  parameter int unsigned NUM_VECTORS   = 16,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED          = 32'hACE12345
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  alucontrol,
  input  logic [31:0] result,
  input  logic        zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  error_count,
  output logic        fail_valid,
  output logic [7:0]  fail_index,
  output logic [2:0]  fail_op
);
  localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] TAPS        = 32'h80200003;
  localparam logic [7:0]  LAST_IDX    = 8'(NUM_VECTORS - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam bit          NO_WAIT     = (SETTLE_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'd0);
  endfunction

  function automatic logic [2:0] op_of(input logic [2:0] sel);
    case (sel)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return 3'b010;
      3'd3:    return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  state_t      state, state_next;
  logic [7:0]  idx;
  logic [2:0]  op_sel;
  logic [31:0] lfsr;
  logic [3:0]  settle_cnt;
  logic        load, restart, check, last;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    restart    = 1'b0;
    check      = 1'b0;
    last       = (idx == LAST_IDX);
    case (state)
      S_IDLE, S_DONE: if (start) begin
        restart    = 1'b1;
        load       = 1'b1;
        state_next = NO_WAIT ? S_CHECK : S_WAIT;
      end
      S_WAIT: if (settle_cnt == SETTLE_LAST) state_next = S_CHECK;
      S_CHECK: begin
        check = 1'b1;
        if (last) state_next = S_DONE;
        else begin
          load       = 1'b1;
          state_next = NO_WAIT ? S_CHECK : S_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-vector generation; a restart rewinds the LFSR to the seed before stepping.
  logic [7:0]  load_idx;
  logic [2:0]  load_sel;
  logic [31:0] lfsr_base, step1, step2;
  logic        directed;

  always_comb begin
    load_idx  = restart ? 8'd0 : idx + 8'd1;
    load_sel  = (restart || op_sel == 3'd4) ? 3'd0 : op_sel + 3'd1;
    lfsr_base = restart ? SEED_EFF : lfsr;
    step1     = lfsr_step(lfsr_base);
    step2     = lfsr_step(step1);
    directed  = (load_idx < 8'd5);
  end

  logic [31:0] exp_result;
  logic        mismatch;
  logic [7:0]  err_next;

  always_comb begin
    case (alucontrol)
      3'b000:  exp_result = a & b;
      3'b001:  exp_result = a | b;
      3'b010:  exp_result = a + b;
      3'b110:  exp_result = a - b;
      3'b111:  exp_result = {31'd0, ($signed(a) < $signed(b))};
      default: exp_result = 32'd0;
    endcase
    mismatch = (result != exp_result) || (zero != (exp_result == 32'd0));
    err_next = (check && mismatch && error_count != 8'hFF) ? error_count + 8'd1 : error_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a           <= '0;
      b           <= '0;
      alucontrol  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_count <= '0;
      fail_valid  <= 1'b0;
      fail_index  <= '0;
      fail_op     <= '0;
      idx         <= '0;
      op_sel      <= '0;
      lfsr        <= SEED_EFF;
      settle_cnt  <= '0;
    end else begin
      if (load) begin
        idx        <= load_idx;
        op_sel     <= load_sel;
        alucontrol <= op_of(load_sel);
        settle_cnt <= '0;
        if (directed) begin
          a    <= 32'd170;
          b    <= 32'd85;
          lfsr <= lfsr_base;
        end else begin
          a    <= step1;
          b    <= step2;
          lfsr <= step2;
        end
      end else if (state == S_WAIT) begin
        settle_cnt <= settle_cnt + 4'd1;
      end

      error_count <= restart ? 8'd0 : err_next;

      if (restart) begin
        busy       <= 1'b1;
        done       <= 1'b0;
        pass       <= 1'b0;
        fail_valid <= 1'b0;
        fail_index <= '0;
        fail_op    <= '0;
      end

      if (check && mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_index <= idx;
        fail_op    <= alucontrol;
      end

      // pass must reflect this final vector's outcome, hence err_next.
      if (check && last) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_next == 8'd0);
      end
    end
  end
endmodule

// File: tb/tb_alu_vector_driver.sv
// Bench for alu_vector_driver: three instances (different vector counts, settle times, seeds)
// each driving an emulated ALU with selectable faults, checked against a reference model.
module tb_alu_vector_driver;
  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s [ND];
  logic [31:0] a_s     [ND];
  logic [31:0] b_s     [ND];
  logic [2:0]  op_s    [ND];
  logic [31:0] res_s   [ND];
  logic        zero_s  [ND];
  logic        busy_s  [ND];
  logic        done_s  [ND];
  logic        pass_s  [ND];
  logic [7:0]  err_s   [ND];
  logic        fv_s    [ND];
  logic [7:0]  fidx_s  [ND];
  logic [2:0]  fop_s   [ND];
  int          mode    [ND];
  logic [4:0]  fmask   [ND];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_vector_driver #(.NUM_VECTORS(5), .SETTLE_CYCLES(1)) u_d0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]), .alucontrol(op_s[0]),
    .result(res_s[0]), .zero(zero_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .error_count(err_s[0]), .fail_valid(fv_s[0]), .fail_index(fidx_s[0]), .fail_op(fop_s[0]));

  alu_vector_driver #(.NUM_VECTORS(16), .SETTLE_CYCLES(0)) u_d1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]), .alucontrol(op_s[1]),
    .result(res_s[1]), .zero(zero_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .error_count(err_s[1]), .fail_valid(fv_s[1]), .fail_index(fidx_s[1]), .fail_op(fop_s[1]));

  alu_vector_driver #(.NUM_VECTORS(255), .SETTLE_CYCLES(2), .SEED(32'h0)) u_d2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]), .alucontrol(op_s[2]),
    .result(res_s[2]), .zero(zero_s[2]), .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
    .error_count(err_s[2]), .fail_valid(fv_s[2]), .fail_index(fidx_s[2]), .fail_op(fop_s[2]));

  function automatic int nv(input int d);
    return (d == 0) ? 5 : (d == 1) ? 16 : 255;
  endfunction
  function automatic int sv(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 2;
  endfunction
  function automatic logic [31:0] seed_of(input int d);
    return (d == 2) ? 32'h0 : 32'hACE12345;
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    case (op)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int slot(input logic [2:0] op);
    case (op)
      3'b000: return 0;
      3'b001: return 1;
      3'b010: return 2;
      3'b110: return 3;
      3'b111: return 4;
      default: return 5;
    endcase
  endfunction

  // Emulated ALU: 0 correct, 1 result stuck 0 / zero stuck 1, 2 constant 7, 3 bit-0 flip on masked ops.
  function automatic logic [32:0] alu_emul(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op,
                                           input int md, input logic [4:0] mk);
    logic [31:0] r;
    r = golden(x, y, op);
    case (md)
      1: return {1'b1, 32'd0};
      2: return {1'b0, 32'd7};
      3: begin
        if (slot(op) < 5 && mk[slot(op)]) r = r ^ 32'd1;
        return {(r == 32'd0), r};
      end
      default: return {(r == 32'd0), r};
    endcase
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_alu
    assign {zero_s[g], res_s[g]} = alu_emul(a_s[g], b_s[g], op_s[g], mode[g], fmask[g]);
  end

  logic [31:0] ref_a [256];
  logic [31:0] ref_b [256];
  logic [2:0]  ref_op[256];

  task automatic build_ref(input int d);
    logic [31:0] s;
    logic [2:0] ops [5];
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    s = (seed_of(d) == 32'd0) ? 32'd1 : seed_of(d);
    for (int i = 0; i < 256; i++) begin
      ref_op[i] = ops[i % 5];
      if (i < 5) begin
        ref_a[i] = 32'd170;
        ref_b[i] = 32'd85;
      end else begin
        s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'd0);
        ref_a[i] = s;
        s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'd0);
        ref_b[i] = s;
      end
    end
  endtask

  int          exp_err, exp_fi;
  logic        exp_fv;
  logic [2:0]  exp_fo;

  task automatic expect_for(input int d);
    int cnt = 0;
    logic [31:0] g;
    exp_fv = 1'b0; exp_fi = 0; exp_fo = 3'b000;
    for (int i = 0; i < nv(d); i++) begin
      g = golden(ref_a[i], ref_b[i], ref_op[i]);
      if (alu_emul(ref_a[i], ref_b[i], ref_op[i], mode[d], fmask[d]) !== {(g == 32'd0), g}) begin
        cnt++;
        if (!exp_fv) begin exp_fv = 1'b1; exp_fi = i; exp_fo = ref_op[i]; end
      end
    end
    exp_err = (cnt > 255) ? 255 : cnt;
  endtask

  int          obs_done_edge, obs_vec_err, obs_busy_err, obs_overlap;
  logic [7:0]  obs_err0;
  logic        obs_fv0, obs_hold_ok;
  logic [31:0] obs_a [256];
  logic [31:0] obs_b [256];
  logic [2:0]  obs_op[256];

  // Pulses start, then walks edge by edge collecting what the DUT drives until done (bounded).
  task automatic run_dut(input int d, input int poke);
    int n, s, budget, k;
    n = nv(d); s = sv(d); budget = n * (s + 1) + 4;
    build_ref(d);
    obs_done_edge = -1; obs_vec_err = 0; obs_busy_err = 0; obs_overlap = 0;
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    obs_err0 = err_s[d];
    obs_fv0  = fv_s[d];
    for (int e = 0; e <= budget; e++) begin
      if (e > 0) begin @(posedge clk); #1; start_s[d] = 1'b0; end
      if (busy_s[d] && done_s[d]) obs_overlap++;
      if (done_s[d]) begin obs_done_edge = e; break; end
      if (!busy_s[d]) obs_busy_err++;
      k = e / (s + 1);
      if (k < 256 && e % (s + 1) == 0) begin
        obs_a[k] = a_s[d]; obs_b[k] = b_s[d]; obs_op[k] = op_s[d];
      end
      if (k >= n || a_s[d] !== ref_a[k] || b_s[d] !== ref_b[k] || op_s[d] !== ref_op[k]) obs_vec_err++;
      if (e == poke) start_s[d] = 1'b1;
    end
    obs_hold_ok = (a_s[d] === ref_a[n-1]) && (b_s[d] === ref_b[n-1]) && (op_s[d] === ref_op[n-1]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      tests++;
      if ({a_s[d], b_s[d], op_s[d], busy_s[d], done_s[d], pass_s[d], err_s[d], fv_s[d], fidx_s[d], fop_s[d]} !== 90'd0) begin
        fails++;
        $display("FAIL reset_outputs d%0d: got a=%h b=%h op=%b busy=%b done=%b err=%0d fv=%b, expected all 0",
                 d, a_s[d], b_s[d], op_s[d], busy_s[d], done_s[d], err_s[d], fv_s[d]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    mode[0] = 0;
    run_dut(0, -1);
    tests++;
    if (obs_done_edge !== 10) begin fails++; $display("FAIL directed_done_edge: got %0d expected 10", obs_done_edge); end
    tests++;
    if (obs_vec_err !== 0) begin fails++; $display("FAIL directed_vectors: got %0d bad cycles expected 0", obs_vec_err); end
    tests++;
    if (obs_busy_err + obs_overlap !== 0) begin
      fails++; $display("FAIL directed_busy: got %0d busy gaps, %0d overlaps expected 0", obs_busy_err, obs_overlap);
    end
    tests++;
    if ({pass_s[0], err_s[0], fv_s[0]} !== {1'b1, 8'd0, 1'b0}) begin
      fails++; $display("FAIL directed_report: got pass=%b err=%0d fv=%b expected 1/0/0", pass_s[0], err_s[0], fv_s[0]);
    end
    tests++;
    if (!obs_hold_ok) begin fails++; $display("FAIL directed_hold: got a=%0d b=%0d op=%b expected last vector", a_s[0], b_s[0], op_s[0]); end
  endtask

  task automatic test_stuck_alu();
    mode[0] = 1;
    run_dut(0, -1);
    expect_for(0);
    tests++;
    if (err_s[0] !== 8'(exp_err) || pass_s[0] !== 1'b0) begin
      fails++; $display("FAIL stuck_count: got err=%0d pass=%b expected err=%0d pass=0", err_s[0], pass_s[0], exp_err);
    end
    tests++;
    if ({fv_s[0], fidx_s[0], fop_s[0]} !== {exp_fv, 8'(exp_fi), exp_fo}) begin
      fails++; $display("FAIL stuck_first: got fv=%b idx=%0d op=%b expected fv=%b idx=%0d op=%b",
                        fv_s[0], fidx_s[0], fop_s[0], exp_fv, exp_fi, exp_fo);
    end
  endtask

  task automatic test_restart_clears();
    mode[0] = 0;
    run_dut(0, -1);
    tests++;
    if (obs_err0 !== 8'd0 || obs_fv0 !== 1'b0) begin
      fails++; $display("FAIL restart_clear: got err=%0d fv=%b after restart expected 0/0", obs_err0, obs_fv0);
    end
    tests++;
    if ({obs_a[0], obs_b[0], obs_op[0]} !== {32'd170, 32'd85, 3'b000}) begin
      fails++; $display("FAIL restart_vec0: got %0d,%0d,%b expected 170,85,000", obs_a[0], obs_b[0], obs_op[0]);
    end
    tests++;
    if (pass_s[0] !== 1'b1 || obs_done_edge !== 10) begin
      fails++; $display("FAIL restart_run: got pass=%b done_edge=%0d expected 1/10", pass_s[0], obs_done_edge);
    end
  endtask

  task automatic test_lfsr();
    mode[1] = 0;
    run_dut(1, -1);
    tests++;
    if (obs_done_edge !== 16 || pass_s[1] !== 1'b1) begin
      fails++; $display("FAIL lfsr_run: got done_edge=%0d pass=%b expected 16/1", obs_done_edge, pass_s[1]);
    end
    tests++;
    if ({obs_a[5], obs_b[5], obs_op[5]} !== {ref_a[5], ref_b[5], 3'b000}) begin
      fails++; $display("FAIL lfsr_vec5: got %h,%h,%b expected %h,%h,000", obs_a[5], obs_b[5], obs_op[5], ref_a[5], ref_b[5]);
    end
    tests++;
    if (obs_vec_err !== 0) begin fails++; $display("FAIL lfsr_vectors: got %0d bad cycles expected 0", obs_vec_err); end
  endtask

  task automatic test_reset_midrun();
    mode[0] = 0;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if ({a_s[0], b_s[0], op_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0], fv_s[0], fidx_s[0], fop_s[0]} !== 90'd0) begin
      fails++; $display("FAIL midrun_reset: got a=%h b=%h op=%b busy=%b done=%b expected all 0",
                        a_s[0], b_s[0], op_s[0], busy_s[0], done_s[0]);
    end
    run_dut(0, -1);
    tests++;
    if (obs_vec_err !== 0 || obs_done_edge !== 10 || pass_s[0] !== 1'b1) begin
      fails++; $display("FAIL midrun_rerun: got bad=%0d done_edge=%0d pass=%b expected 0/10/1",
                        obs_vec_err, obs_done_edge, pass_s[0]);
    end
  endtask

  task automatic test_start_while_busy();
    mode[1] = 0;
    run_dut(1, 3);
    tests++;
    if (obs_done_edge !== 16 || obs_vec_err !== 0 || obs_overlap !== 0) begin
      fails++; $display("FAIL busy_start: got done_edge=%0d bad=%0d overlap=%0d expected 16/0/0",
                        obs_done_edge, obs_vec_err, obs_overlap);
    end
  endtask

  task automatic test_random_faults();
    for (int it = 0; it < 6; it++) begin
      mode[1]  = 3;
      fmask[1] = 5'($urandom_range(0, 31));
      run_dut(1, int'($urandom_range(0, 14)));
      expect_for(1);
      tests++;
      if (err_s[1] !== 8'(exp_err) || pass_s[1] !== (exp_err == 0)) begin
        fails++; $display("FAIL rand_count mask=%b: got err=%0d pass=%b expected err=%0d", fmask[1], err_s[1], pass_s[1], exp_err);
      end
      tests++;
      if ({fv_s[1], fidx_s[1], fop_s[1]} !== {exp_fv, 8'(exp_fi), exp_fo} || obs_done_edge !== 16) begin
        fails++; $display("FAIL rand_first mask=%b: got fv=%b idx=%0d op=%b edge=%0d expected fv=%b idx=%0d op=%b edge=16",
                          fmask[1], fv_s[1], fidx_s[1], fop_s[1], obs_done_edge, exp_fv, exp_fi, exp_fo);
      end
    end
    mode[1] = 0;
  endtask

  task automatic test_saturate();
    mode[2] = 2;
    run_dut(2, -1);
    expect_for(2);
    tests++;
    if (err_s[2] !== 8'(exp_err) || exp_err !== 255) begin
      fails++; $display("FAIL sat_count: got err=%0d expected 255 (model %0d)", err_s[2], exp_err);
    end
    tests++;
    if ({pass_s[2], fv_s[2], fidx_s[2], fop_s[2]} !== {1'b0, 1'b1, 8'd0, 3'b000} || obs_done_edge !== 765) begin
      fails++; $display("FAIL sat_report: got pass=%b fv=%b idx=%0d op=%b edge=%0d expected 0/1/0/000/765",
                        pass_s[2], fv_s[2], fidx_s[2], fop_s[2], obs_done_edge);
    end
    mode[2] = 0;
    run_dut(2, -1);
    tests++;
    if (obs_vec_err !== 0 || pass_s[2] !== 1'b1 || err_s[2] !== 8'd0) begin
      fails++; $display("FAIL seed0_run: got bad=%0d pass=%b err=%0d expected 0/1/0", obs_vec_err, pass_s[2], err_s[2]);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      start_s[d] = 1'b0;
      mode[d]    = 0;
      fmask[d]   = 5'd0;
    end
    test_reset();
    test_directed();
    test_stuck_alu();
    test_restart_clears();
    test_lfsr();
    test_reset_midrun();
    test_start_while_busy();
    test_random_faults();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
